// File: rtl/fp_addsub_pipe.sv
// -----------------------------------------------------------------------------
// fp_addsub_pipe
// Pipelined floating-point adder/subtractor for a parameterised binary format
// {sign, exponent[EXP_W], mantissa[MAN_W]}. Three stages:
//   S1 unpack, classify special operands, order by magnitude, align the smaller
//   S2 add or subtract the aligned significands
//   S3 normalise, round to nearest-even, detect overflow/underflow, pack
// Subnormal inputs are flushed to signed zero and no subnormal is produced.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair present on a/b/sub
//   in_ready   pipeline accepts operands this cycle
//   a, b       operands
//   sub        0: a+b, 1: a-b
//   out_valid  result/flags present
//   out_ready  consumer accepts result
//   result     rounded sum or difference
//   flags      {nv, of, uf, nx}
// -----------------------------------------------------------------------------
module fp_addsub_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags
);

    localparam int W       = 1 + EXP_W + MAN_W;
    localparam int BIAS    = (1 << (EXP_W - 1)) - 1;
    // All-ones exponent (inf/NaN encoding) equals 2*BIAS+1
    localparam int EXP_INF = 2 * BIAS + 1;
    // Significand with hidden bit plus guard/round/sticky
    localparam int SW      = MAN_W + 4;
    // Normalised significand without the hidden bit
    localparam int NW      = SW - 1;
    // Signed working exponent, wide enough for exp - leading-zero count
    localparam int XW      = EXP_W + 8;
    localparam int LZW     = $clog2(SW + 1);

    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    logic en;

    // Stage registers
    logic             s1_valid, s1_special, s1_sign, s1_eff_sub;
    logic [W-1:0]     s1_spec_res;
    logic [3:0]       s1_spec_flags;
    logic [EXP_W-1:0] s1_exp;
    logic [SW-1:0]    s1_big, s1_small;

    logic             s2_valid, s2_special, s2_sign;
    logic [W-1:0]     s2_spec_res;
    logic [3:0]       s2_spec_flags;
    logic [EXP_W-1:0] s2_exp;
    logic [SW:0]      s2_sum;

    // The whole pipeline moves as one; a stalled output freezes every stage
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // ---------------- S1 combinational: unpack / classify / swap / align ----
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic             c1_special, swap;
    logic [W-1:0]     c1_spec_res;
    logic [3:0]       c1_spec_flags;
    logic             big_sign;
    logic [EXP_W-1:0] big_exp, small_exp, diff;
    logic [MAN_W-1:0] big_man, small_man;
    logic [SW-1:0]    big_sig, small_ext, shifted, lost, small_sig;

    assign sa = a[W-1];
    assign sb = b[W-1] ^ sub;
    assign ea = a[W-2:MAN_W];
    assign eb = b[W-2:MAN_W];
    assign ma = a[MAN_W-1:0];
    assign mb = b[MAN_W-1:0];

    always_comb begin
        a_nan  = (ea == EXP_ONES) && (ma != '0);
        b_nan  = (eb == EXP_ONES) && (mb != '0);
        a_inf  = (ea == EXP_ONES) && (ma == '0);
        b_inf  = (eb == EXP_ONES) && (mb == '0);
        a_zero = (ea == '0);
        b_zero = (eb == '0);

        // Special operands bypass the arithmetic and ride the pipeline as a
        // precomputed result
        c1_special    = 1'b1;
        c1_spec_res   = '0;
        c1_spec_flags = 4'b0000;
        if (a_nan || b_nan) begin
            c1_spec_res = QNAN;
        end else if (a_inf && b_inf && (sa != sb)) begin
            c1_spec_res   = QNAN;
            c1_spec_flags = 4'b1000;
        end else if (a_inf) begin
            c1_spec_res = {sa, EXP_ONES, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            c1_spec_res = {sb, EXP_ONES, {MAN_W{1'b0}}};
        end else if (a_zero && b_zero) begin
            c1_spec_res = {sa & sb, {(W-1){1'b0}}};
        end else if (a_zero) begin
            c1_spec_res = {sb, eb, mb};
        end else if (b_zero) begin
            c1_spec_res = a;
        end else begin
            c1_special = 1'b0;
        end

        swap      = {eb, mb} > {ea, ma};
        big_sign  = swap ? sb : sa;
        big_exp   = swap ? eb : ea;
        big_man   = swap ? mb : ma;
        small_exp = swap ? ea : eb;
        small_man = swap ? ma : mb;
        diff      = big_exp - small_exp;

        big_sig   = {1'b1, big_man, 3'b000};
        small_ext = {1'b1, small_man, 3'b000};
        shifted   = small_ext >> diff;
        lost      = small_ext & ~({SW{1'b1}} << diff);
        // Bits shifted past the round position collapse into the sticky bit
        if (int'(diff) >= MAN_W + 3) begin
            small_sig = SW'(1);
        end else begin
            small_sig = shifted | SW'(|lost);
        end
    end

    // ---------------- S2 combinational: magnitude add/subtract --------------
    // The larger magnitude is always primary, so the difference never borrows
    logic [SW:0] c2_sum;
    assign c2_sum = s1_eff_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                               : ({1'b0, s1_big} + {1'b0, s1_small});

    // ---------------- S3 combinational: normalise / round / pack ------------
    logic [LZW-1:0] lzc;
    logic [NW-1:0]  norm;
    logic [XW-1:0]  exp_n, exp_r;
    logic [MAN_W:0] man_rnd;
    logic           round_up, inexact, underflow;
    logic [W-1:0]   c3_result;
    logic [3:0]     c3_flags;

    always_comb begin
        lzc = LZW'(SW);
        for (int i = 0; i < SW; i++) begin
            if (s2_sum[i]) lzc = LZW'(SW - 1 - i);
        end

        // A carry out shifts right by one, folding the dropped bit into sticky
        if (s2_sum[SW]) begin
            norm  = {s2_sum[SW-1:2], s2_sum[1] | s2_sum[0]};
            exp_n = XW'(s2_exp) + XW'(1);
        end else begin
            norm  = NW'(s2_sum[SW-1:0] << lzc);
            exp_n = XW'(s2_exp) - XW'(lzc);
        end

        inexact   = |norm[2:0];
        round_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
        man_rnd   = {1'b0, norm[NW-1:3]} + (MAN_W+1)'(round_up);
        // Mantissa overflow from rounding leaves all-zero fraction, exponent+1
        exp_r     = exp_n + XW'(man_rnd[MAN_W]);
        underflow = exp_n[XW-1] || (exp_n == '0);

        if (s2_special) begin
            c3_result = s2_spec_res;
            c3_flags  = s2_spec_flags;
        end else if (s2_sum == '0) begin
            c3_result = '0;
            c3_flags  = 4'b0000;
        end else if (underflow) begin
            c3_result = {s2_sign, {(W-1){1'b0}}};
            c3_flags  = 4'b0011;
        end else if (exp_r >= XW'(EXP_INF)) begin
            c3_result = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
            c3_flags  = 4'b0101;
        end else begin
            c3_result = {s2_sign, exp_r[EXP_W-1:0], man_rnd[MAN_W-1:0]};
            c3_flags  = {3'b000, inexact};
        end
    end

    // ---------------- Pipeline registers ------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid      <= 1'b0;
            s1_special    <= 1'b0;
            s1_spec_res   <= '0;
            s1_spec_flags <= 4'b0000;
            s1_sign       <= 1'b0;
            s1_eff_sub    <= 1'b0;
            s1_exp        <= '0;
            s1_big        <= '0;
            s1_small      <= '0;
            s2_valid      <= 1'b0;
            s2_special    <= 1'b0;
            s2_spec_res   <= '0;
            s2_spec_flags <= 4'b0000;
            s2_sign       <= 1'b0;
            s2_exp        <= '0;
            s2_sum        <= '0;
            out_valid     <= 1'b0;
            result        <= '0;
            flags         <= 4'b0000;
        end else if (en) begin
            s1_valid      <= in_valid;
            s1_special    <= c1_special;
            s1_spec_res   <= c1_spec_res;
            s1_spec_flags <= c1_spec_flags;
            s1_sign       <= big_sign;
            s1_eff_sub    <= sa ^ sb;
            s1_exp        <= big_exp;
            s1_big        <= big_sig;
            s1_small      <= small_sig;

            s2_valid      <= s1_valid;
            s2_special    <= s1_special;
            s2_spec_res   <= s1_spec_res;
            s2_spec_flags <= s1_spec_flags;
            s2_sign       <= s1_sign;
            s2_exp        <= s1_exp;
            s2_sum        <= c2_sum;

            out_valid     <= s2_valid;
            result        <= c3_result;
            flags         <= c3_flags;
        end
    end

endmodule
